seg_pattern_decoder: RTL
========================

Name: seg_pattern_decoder

Overview:
- Receive-side counterpart of the turnstile 7-segment encoder.
- Samples the two active-low segment buses (seg, seg2), filters glitches, and decodes each stable pattern back to the turnstile's 4-bit display code.
- Presents the decoded pair on a valid/ready output for display loopback checking and for the fare/state logic.
- Unknown stable patterns are flagged per channel.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples needed to accept a pattern (legal range 1..255)
CNT_W, 8, width of optional error counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
seg  in  7  channel 0 segment pattern, active-low, bit0 = segment a
seg2  in  7  channel 1 segment pattern, same format
out_ready  in  1  consumer accepts the decoded pair
data  out  4  decoded channel 0 code
data2  out  4  decoded channel 1 code
out_valid  out  1  decoded pair pending
err  out  1  channel 0 last stable pattern unknown
err2  out  1  channel 1 last stable pattern unknown
err_count  out  CNT_W  only with SEG_ERRCNT_EN

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Decode table, identical for both channels (pattern -> code):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 1110111->8, 1111110->9, 0101011->A, 1111111->B (blank), 1000010->F
  - Any other pattern is unknown. Codes C, D and E are never produced.
- Per-channel stability filter:
  - Registers: prev[6:0] and cnt (8 bits).
  - Each edge: if input == prev, cnt <= min(cnt+1, STABLE_CYCLES); else cnt <= 1. prev <= input.
  - Commit event: the edge on which cnt becomes STABLE_CYCLES from a lower value. A pattern held for STABLE_CYCLES edges commits once. Holding it longer does nothing.
- On commit with a known pattern:
  - err/err2 cleared.
  - If the code differs from the committed code, the committed code is updated and a change event is raised.
  - If the code is the same, there is no event.
- On commit with an unknown pattern: err/err2 set; the committed code is unchanged; no change event. The flag is sticky until the next commit of a known pattern.
- Output FSM, states IDLE and PEND:
  - IDLE: out_valid=0. A change event on either channel -> PEND. data/data2 load both committed codes on the same edge.
  - PEND: out_valid=1, data/data2 held stable while out_ready=0.
  - PEND with out_ready=1 and no new event -> IDLE.
  - New event while in PEND, with or without out_ready: data/data2 reload the newest pair and the state stays PEND (latest wins, no queueing).
  - Events on both channels in the same cycle produce one update carrying both new codes.
- Latency: a new pattern first presented before edge k and held commits at edge k+STABLE_CYCLES-1. out_valid/data are visible after that edge. With STABLE_CYCLES=1, the commit happens at edge k.
- A glitch shorter than STABLE_CYCLES never changes data, err, or err_count.
- Reset values:
  - prev = 7'b1111111, cnt = 0.
  - Committed codes = 4'hB.
  - data = data2 = 4'hB, out_valid = 0, err = err2 = 0, err_count = 0, state IDLE.
- Reset asserted mid-filter or in PEND discards everything. After release, a blank 1111111 input commits with no event, because it matches reset code B.

Optional Feature:
- Macro: SEG_ERRCNT_EN.
- Defined:
  - err_count increments once per unknown-pattern commit, per channel. Two simultaneous unknown commits add 2.
  - Saturates at all-ones. Cleared only by rst.
- Undefined: err_count port and counter absent; all other behaviour identical.

Test Plan:
- Reset, both inputs 1111111 held 10 cycles -> data=data2=B, out_valid stays 0, err=err2=0.
- seg=0100100 held from edge 0, STABLE_CYCLES=4, out_ready=0 -> out_valid rises after edge 3, data=2, data2=B; held unchanged 20 cycles; out_ready=1 for one cycle -> out_valid=0 next cycle.
- seg=0000010 for 3 cycles then back to 1000000 (committed 0) -> no out_valid, data stays 0, err=0.
- While PEND with data=5, seg2 stabilizes to 0101011 -> data2 becomes A in the same PEND; one out_ready handshake returns data=5, data2=A.
- seg=0000000 held 4 cycles -> err=1, data unchanged, out_valid unchanged, err_count=1 (SEG_ERRCNT_EN). Then seg=1111001 held 4 -> err=0, data=1, out_valid=1.
- rst pulsed in PEND with pending data=7 -> next cycle out_valid=0, data=B, err_count=0.

Source files
------------

// File: rtl/seg_pattern_decoder_if.sv
// Segment-bus receive interface: raw active-low patterns in, decoded pair out.
// err_count exists only when SEG_ERRCNT_EN is defined.
interface seg_pattern_decoder_if #(
  parameter int CNT_W = 8
);
  logic [6:0] seg;
  logic [6:0] seg2;
  logic       out_ready;
  logic [3:0] data;
  logic [3:0] data2;
  logic       out_valid;
  logic       err;
  logic       err2;
`ifdef SEG_ERRCNT_EN
  logic [CNT_W-1:0] err_count;

  modport master (
    output seg, seg2, out_ready,
    input  data, data2, out_valid, err, err2, err_count
  );
  modport slave (
    input  seg, seg2, out_ready,
    output data, data2, out_valid, err, err2, err_count
  );
`else
  modport master (
    output seg, seg2, out_ready,
    input  data, data2, out_valid, err, err2
  );
  modport slave (
    input  seg, seg2, out_ready,
    output data, data2, out_valid, err, err2
  );
`endif
endinterface

// File: rtl/seg_pattern_decoder.sv
// Glitch-filtered 7-segment decoder for two channels with a latest-wins valid/ready output.
// Optional SEG_ERRCNT_EN adds a saturating unknown-pattern counter.
module seg_chan #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] code_nxt,
  output logic       chg,
  output logic       unk,
  output logic       err
);
  localparam logic [7:0] S = 8'(STABLE_CYCLES);

  logic [6:0] prev;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] code_q, dec;
  logic       known, commit;

  always_comb begin
    known = 1'b1;
    dec   = 4'hB;
    case (seg_in)
      7'b1000000: dec = 4'h0;
      7'b1111001: dec = 4'h1;
      7'b0100100: dec = 4'h2;
      7'b0110000: dec = 4'h3;
      7'b0011001: dec = 4'h4;
      7'b0010010: dec = 4'h5;
      7'b0000010: dec = 4'h6;
      7'b1111000: dec = 4'h7;
      7'b1110111: dec = 4'h8;
      7'b1111110: dec = 4'h9;
      7'b0101011: dec = 4'hA;
      7'b1111111: dec = 4'hB;
      7'b1000010: dec = 4'hF;
      default:    known = 1'b0;
    endcase
  end

  // A pattern change restarts the count; with S==1 that restart is itself the commit.
  always_comb begin
    if (seg_in == prev) cnt_nxt = (cnt >= S) ? S : cnt + 8'd1;
    else                cnt_nxt = 8'd1;
    commit   = (cnt_nxt == S) && ((cnt != S) || (seg_in != prev));
    chg      = commit && known && (dec != code_q);
    unk      = commit && !known;
    code_nxt = chg ? dec : code_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= 7'b1111111;
      cnt    <= 8'd0;
      code_q <= 4'hB;
      err    <= 1'b0;
    end else begin
      prev   <= seg_in;
      cnt    <= cnt_nxt;
      code_q <= code_nxt;
      if (commit) err <= !known;
    end
  end
endmodule

module seg_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic clk,
  input logic rst,
  seg_pattern_decoder_if.slave bus
);
  typedef enum logic {IDLE, PEND} state_t;

  logic [1:0][6:0] seg_in;
  logic [1:0][3:0] code_nxt;
  logic [1:0]      chg, unk, err_v;
  state_t          state, state_nxt;

  assign seg_in = {bus.seg2, bus.seg};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    seg_chan #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .seg_in   (seg_in[i]),
      .code_nxt (code_nxt[i]),
      .chg      (chg[i]),
      .unk      (unk[i]),
      .err      (err_v[i])
    );
  end

  assign bus.err  = err_v[0];
  assign bus.err2 = err_v[1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|chg) state_nxt = PEND;
      PEND:    if (!(|chg) && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == PEND);
  end

  // Any event reloads both codes, so the newest pair always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data  <= 4'hB;
      bus.data2 <= 4'hB;
    end else if (|chg) begin
      bus.data  <= code_nxt[0];
      bus.data2 <= code_nxt[1];
    end
  end

`ifdef SEG_ERRCNT_EN
  logic [CNT_W-1:0] ecnt;
  logic [CNT_W:0]   esum;

  always_comb begin
    esum = {1'b0, ecnt} + (CNT_W+1)'(unk[0]) + (CNT_W+1)'(unk[1]);
  end

  always_ff @(posedge clk) begin
    if (rst)            ecnt <= '0;
    else if (esum[CNT_W]) ecnt <= '1;
    else                ecnt <= esum[CNT_W-1:0];
  end

  assign bus.err_count = ecnt;
`endif
endmodule
